io_fifo_bridge: RTL and testbench



---
 rtl/io_bridge_pkg.sv | 51 +++++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/io_fifo_bridge.sv | 110 +++++++++++
 tb/tb_io_fifo_bridge.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/io_bridge_pkg.sv
// io_bridge_pkg: shared definitions for the memory-mapped I/O FIFO bridge.
// Holds the register index encoding, STATUS bit positions, the I/O select
// address bit and the STATUS word packing helper.
package io_bridge_pkg;

  localparam int DATA_W     = 32;
  localparam int IO_SEL_BIT = 7;

  // Register index taken from addr[3:2]
  typedef enum logic [1:0] {
    IO_TXDATA = 2'd0,
    IO_RXDATA = 2'd1,
    IO_STATUS = 2'd2,
    IO_RSVD   = 2'd3
  } io_reg_e;

  // STATUS bit positions
  localparam int ST_TX_FULL     = 0;
  localparam int ST_TX_EMPTY    = 1;
  localparam int ST_RX_FULL     = 2;
  localparam int ST_RX_EMPTY    = 3;
  localparam int ST_TX_DROP     = 4;
  localparam int ST_RX_UNDERFLW = 5;
  localparam int ST_TX_CNT_LSB  = 8;
  localparam int ST_RX_CNT_LSB  = 16;

  // Counts arrive zero-extended to 32 bits; only the low byte is reported.
  function automatic logic [DATA_W-1:0] pack_status(
    input logic        tx_full,
    input logic        tx_empty,
    input logic        rx_full,
    input logic        rx_empty,
    input logic        tx_drop,
    input logic        rx_underflow,
    input logic [31:0] tx_count,
    input logic [31:0] rx_count
  );
    logic [DATA_W-1:0] s;
    s = '0;
    s[ST_TX_FULL]                    = tx_full;
    s[ST_TX_EMPTY]                   = tx_empty;
    s[ST_RX_FULL]                    = rx_full;
    s[ST_RX_EMPTY]                   = rx_empty;
    s[ST_TX_DROP]                    = tx_drop;
    s[ST_RX_UNDERFLW]                = rx_underflow;
    s[ST_TX_CNT_LSB +: 8]            = tx_count[7:0];
    s[ST_RX_CNT_LSB +: 8]            = rx_count[7:0];
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, DEPTH entries of DATA_W bits.
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   push, din         - write request and data (ignored when full unless a
//                       pop happens in the same cycle)
//   pop, dout         - read request (ignored when empty) and head data
//   count, full, empty- occupancy, 0..DEPTH
// Push and pop together both take effect and leave count unchanged; on an
// empty FIFO the pop is dropped and the push still proceeds.
module sync_fifo
  import io_bridge_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = io_bridge_pkg::DATA_W,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only and is never cleared.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/io_fifo_bridge.sv
// io_fifo_bridge: memory-mapped I/O responder bridging CPU loads/stores to a
// device-side TX FIFO (CPU -> device) and RX FIFO (device -> CPU).
// Ports:
//   clock, reset         - rising-edge clock, synchronous active-high reset
//   addr, wdata, we, re  - MEM-stage access; addr[7] selects I/O space,
//                          addr[3:2] picks TXDATA/RXDATA/STATUS/reserved
//   rdata                - combinational load data (0 unless a selected load)
//   tx_valid/data/ready  - TX FIFO head offered to the device
//   rx_valid/data/ready  - device words into the RX FIFO
module io_fifo_bridge
  import io_bridge_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              we,
  input  logic              re,
  output logic [31:0]       rdata,
  output logic              tx_valid,
  output logic [31:0]       tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [31:0]       rx_data,
  output logic              rx_ready
);

  io_reg_e     reg_idx;
  logic        io_sel;
  logic        tx_push_req;
  logic        rx_pop_req;
  logic        status_wr;
  logic        tx_pop;
  logic        rx_push;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic [AW:0] tx_count, rx_count;
  logic [31:0] rx_head;
  logic        tx_drop;
  logic        rx_underflow;
  logic        unused_addr_bits;

  assign io_sel      = addr[IO_SEL_BIT];
  assign reg_idx     = io_reg_e'(addr[3:2]);
  assign tx_push_req = io_sel & we & (reg_idx == IO_TXDATA);
  assign rx_pop_req  = io_sel & re & (reg_idx == IO_RXDATA);
  assign status_wr   = io_sel & we & (reg_idx == IO_STATUS);

  assign tx_valid    = ~tx_empty;
  assign rx_ready    = ~rx_full;
  assign tx_pop      = tx_valid & tx_ready;
  assign rx_push     = rx_valid & rx_ready;

  // Aliased and byte-offset address bits carry no meaning here.
  assign unused_addr_bits = ^{addr[31:8], addr[6:4], addr[1:0]};

  sync_fifo #(.DEPTH(DEPTH), .DATA_W(32), .AW(AW)) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (tx_push_req),
    .pop   (tx_pop),
    .din   (wdata),
    .dout  (tx_data),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // The FIFO itself ignores a pop on empty; the underflow flag records it.
  sync_fifo #(.DEPTH(DEPTH), .DATA_W(32), .AW(AW)) u_rx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop_req),
    .din   (rx_data),
    .dout  (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // Sticky error flags: TX store lost to a full FIFO, RX load on empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_drop      <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      if (tx_push_req && tx_full && !tx_pop) tx_drop <= 1'b1;
      else if (status_wr && wdata[ST_TX_DROP]) tx_drop <= 1'b0;
      if (rx_pop_req && rx_empty) rx_underflow <= 1'b1;
      else if (status_wr && wdata[ST_RX_UNDERFLW]) rx_underflow <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (io_sel && re) begin
      case (reg_idx)
        IO_RXDATA: rdata = rx_empty ? '0 : rx_head;
        IO_STATUS: rdata = pack_status(tx_full, tx_empty, rx_full, rx_empty,
                                       tx_drop, rx_underflow,
                                       32'(tx_count), 32'(rx_count));
        default:   rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_fifo_bridge.sv
// Scoreboard bench for io_fifo_bridge: a queue-based reference model predicts
// per-cycle outputs; a monitor on the falling edge compares them.
module tb_io_fifo_bridge;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0, wdata = '0, rdata, tx_data, rx_data = '0;
  logic        we = 1'b0, re = 1'b0, tx_valid, tx_ready = 1'b0;
  logic        rx_valid = 1'b0, rx_ready;

  typedef struct {
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        rx_ready;
    logic [31:0] rdata;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  bit          m_drop = 0, m_unf = 0;
  int          nchk = 0, npass = 0;

  always #5 clock = ~clock;

  io_fifo_bridge #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
    .re(re), .rdata(rdata), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    nchk++;
    if (act === want) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
  endtask

  function automatic logic [31:0] model_rdata(input logic [31:0] a, input bit r);
    logic [31:0] s;
    logic [1:0]  idx;
    idx = a[3:2];
    if (!(a[7] && r)) return 32'h0;
    case (idx)
      2'd1: return (rxq.size() != 0) ? rxq[0] : 32'h0;
      2'd2: begin
        s = 32'h0;
        s[0] = (txq.size() == DEPTH);
        s[1] = (txq.size() == 0);
        s[2] = (rxq.size() == DEPTH);
        s[3] = (rxq.size() == 0);
        s[4] = m_drop;
        s[5] = m_unf;
        s[15:8]  = 8'(txq.size());
        s[23:16] = 8'(rxq.size());
        return s;
      end
      default: return 32'h0;
    endcase
  endfunction

  // Drive one cycle shortly after the rising edge, record the expected
  // outputs for this cycle, then advance the model past the next edge.
  task automatic cycle(input bit rs, input logic [31:0] a, input logic [31:0] wd,
                       input bit w, input bit r, input bit txr, input bit rxv,
                       input logic [31:0] rxd);
    exp_t        e;
    bit          txpop, rxpush;
    int          tsz;
    logic [1:0]  idx;
    @(posedge clock); #1;
    reset = rs; addr = a; wdata = wd; we = w; re = r;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    e.tx_valid = (txq.size() != 0);
    e.tx_data  = e.tx_valid ? txq[0] : 32'h0;
    e.rx_ready = (rxq.size() != DEPTH);
    e.rdata    = model_rdata(a, r);
    expq.push_back(e);
    idx = a[3:2];
    if (rs) begin
      txq.delete(); rxq.delete(); m_drop = 0; m_unf = 0;
    end else begin
      txpop  = e.tx_valid && txr;
      rxpush = e.rx_ready && rxv;
      tsz    = txq.size();
      if (txpop) void'(txq.pop_front());
      if (a[7] && w && idx == 2'd0) begin
        if (tsz < DEPTH || txpop) txq.push_back(wd);
        else m_drop = 1;
      end
      if (a[7] && r && idx == 2'd1) begin
        if (rxq.size() == 0) m_unf = 1;
        else void'(rxq.pop_front());
      end
      if (rxpush) rxq.push_back(rxd);
      if (a[7] && w && idx == 2'd2) begin
        if (wd[4]) m_drop = 0;
        if (wd[5]) m_unf = 0;
      end
    end
  endtask

  task automatic idle(input bit txr);
    cycle(0, 32'h0, 32'h0, 0, 0, txr, 0, 32'h0);
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit txr);
    cycle(0, a, d, 1, 0, txr, 0, 32'h0);
  endtask
  task automatic load(input logic [31:0] a);
    cycle(0, a, 32'h0, 0, 1, 0, 0, 32'h0);
  endtask

  // Monitor: compare every predicted cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("tx_valid", {31'h0, tx_valid}, {31'h0, e.tx_valid});
        chk("rx_ready", {31'h0, rx_ready}, {31'h0, e.rx_ready});
        chk("rdata", rdata, e.rdata);
        if (e.tx_valid) chk("tx_data", tx_data, e.tx_data);
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          t;
    // Bring the DUT out of reset before the model takes over.
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    load(32'h88);
    @(negedge clock);
    chk("reset_status", rdata, 32'h0000_000A);
    chk("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("reset_rx_ready", {31'h0, rx_ready}, 32'h1);

    // Three stores held back, then drained in order
    store(32'h80, 32'h11, 0);
    store(32'h80, 32'h22, 0);
    store(32'h80, 32'h33, 0);
    repeat (4) idle(1);

    // Overfill: ninth store dropped
    for (int i = 0; i < 9; i++) store(32'h80, 32'h100 + i, 0);
    load(32'h88);
    @(negedge clock);
    chk("overfill_status", rdata, 32'h0000_0819);
    store(32'h88, 32'h10, 0);
    load(32'h88);
    @(negedge clock);
    chk("drop_cleared", rdata, 32'h0000_0809);

    // Full TX, store with simultaneous device pop
    store(32'h80, 32'h99, 1);
    load(32'h88);
    @(negedge clock);
    chk("full_pushpop_count", rdata, 32'h0000_0809);
    repeat (10) idle(1);

    // RX fill to full then drain by loads
    for (int i = 1; i <= 8; i++) cycle(0, 32'h0, 32'h0, 0, 0, 0, 1, 32'hA5A5_0000 + i);
    idle(0);
    @(negedge clock);
    chk("rx_full_ready", {31'h0, rx_ready}, 32'h0);
    for (int i = 0; i < 8; i++) load(32'h84);

    // Underflow, then status shows it
    load(32'h84);
    @(negedge clock);
    chk("underflow_rdata", rdata, 32'h0);
    load(32'h88);
    @(negedge clock);
    chk("underflow_status", rdata, 32'h0000_002A);

    // Reset with both FIFOs holding data
    store(32'h80, 32'hCAFE, 0);
    cycle(0, 32'h0, 32'h0, 0, 0, 0, 1, 32'hBEEF);
    cycle(1, 32'h80, 32'h1, 1, 0, 1, 1, 32'h2);
    load(32'h88);
    @(negedge clock);
    chk("after_reset_status", rdata, 32'h0000_000A);

    // Randomized traffic with phases biased toward full and empty FIFOs
    for (int i = 0; i < 3000; i++) begin
      t = (i / 300) % 3;
      a = $urandom;
      a[7] = ($urandom_range(0, 4) != 0);
      cycle(($urandom_range(0, 400) == 0), a, $urandom,
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            (t == 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1),
            (t == 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) == 0),
            $urandom);
    end
    idle(0);

    // Drain the scoreboard with a bound
    for (int k = 0; k < 10 && expq.size() != 0; k++) @(negedge clock);
    if (expq.size() != 0) begin
      nchk++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", expq.size());
    end
    @(posedge clock);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
